// File: rtl/deadlock_axis_monitor_param.sv
// Deadlock monitor: flags a region where every process is stopped and at least one is AXI-stream blocked.
// Latency: block/block_pulse rise on the edge where the condition has been seen at STABLE_CYCLES consecutive edges.
// Backpressure: none; observe-only, inputs are sampled every cycle and never stalled.
module deadlock_axis_monitor_param #(
    parameter int NUM_PROC      = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int STICKY        = 1,
    parameter int CNT_W         = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                clear,
    input  logic [NUM_PROC-1:0] axis_block_sigs,
    input  logic [NUM_PROC-1:0] inst_idle_sigs,
    input  logic [NUM_PROC-1:0] inst_block_sigs,
    output logic                block,
    output logic                block_pulse,
    output logic [NUM_PROC-1:0] axis_block_info,
    output logic [NUM_PROC-1:0] stop_vec,
    output logic [CNT_W-1:0]    block_count
);

    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMING  = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [RUN_W-1:0]    run_cnt;
    logic [RUN_W-1:0]    run_nxt;
    logic [RUN_W-1:0]    run_inc;
    logic [NUM_PROC-1:0] stop;
    logic [NUM_PROC-1:0] info_nxt;
    logic                has_axis;
    logic                cond;
    logic                block_nxt;
    logic                detect;

    assign stop     = inst_idle_sigs | inst_block_sigs | axis_block_sigs;
    assign has_axis = |axis_block_sigs;
    assign cond     = has_axis & (&stop);
    assign run_inc  = run_cnt + RUN_W'(1);

    always_comb begin
        state_nxt = state;
        run_nxt   = run_cnt;
        block_nxt = block;
        info_nxt  = axis_block_info;
        detect    = 1'b0;
        if (clear) begin
            // clear wins over a detection landing on the same edge
            state_nxt = IDLE;
            run_nxt   = '0;
            block_nxt = 1'b0;
            info_nxt  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable && cond) begin
                        run_nxt = RUN_W'(1);
                        if (STABLE_CYCLES == 1) detect = 1'b1;
                        else                    state_nxt = ARMING;
                    end else begin
                        run_nxt = '0;
                    end
                end
                ARMING: begin
                    if (!enable || !cond) begin
                        state_nxt = IDLE;
                        run_nxt   = '0;
                    end else begin
                        run_nxt = run_inc;
                        if (run_inc == RUN_TARGET) detect = 1'b1;
                    end
                end
                BLOCKED: begin
                    if (STICKY == 0) begin
                        if (cond) begin
                            info_nxt = axis_block_sigs;
                        end else begin
                            state_nxt = IDLE;
                            run_nxt   = '0;
                            block_nxt = 1'b0;
                            info_nxt  = '0;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    run_nxt   = '0;
                end
            endcase
            if (detect) begin
                state_nxt = BLOCKED;
                block_nxt = 1'b1;
                info_nxt  = axis_block_sigs;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            run_cnt         <= '0;
            block           <= 1'b0;
            block_pulse     <= 1'b0;
            axis_block_info <= '0;
            stop_vec        <= '0;
            block_count     <= '0;
        end else begin
            state           <= state_nxt;
            run_cnt         <= run_nxt;
            block           <= block_nxt;
            block_pulse     <= detect;
            axis_block_info <= info_nxt;
            stop_vec        <= stop;
            if (detect && (block_count != '1)) block_count <= block_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_deadlock_axis_monitor_param.sv
// Bench for deadlock_axis_monitor_param: sticky/slow instance a and transient/fast instance b on shared inputs.
module tb_deadlock_axis_monitor_param;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       clear;
    logic [1:0] axis_block_sigs;
    logic [1:0] inst_idle_sigs;
    logic [1:0] inst_block_sigs;

    logic       blk_a, pls_a, blk_b, pls_b;
    logic [1:0] info_a, stop_a, info_b, stop_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    deadlock_axis_monitor_param #(
        .NUM_PROC(2), .STABLE_CYCLES(4), .STICKY(1), .CNT_W(8)
    ) u_a (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
        .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs), .block(blk_a), .block_pulse(pls_a),
        .axis_block_info(info_a), .stop_vec(stop_a), .block_count(cnt_a)
    );

    deadlock_axis_monitor_param #(
        .NUM_PROC(2), .STABLE_CYCLES(1), .STICKY(0), .CNT_W(2)
    ) u_b (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
        .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs), .block(blk_b), .block_pulse(pls_b),
        .axis_block_info(info_b), .stop_vec(stop_b), .block_count(cnt_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: index 0 = instance a, 1 = instance b.
    int         p_stable [2] = '{4, 1};
    bit         p_sticky [2] = '{1'b1, 1'b0};
    int         p_max    [2] = '{255, 3};
    int         m_run    [2];
    bit         m_blk    [2];
    bit         m_pls    [2];
    logic [1:0] m_info   [2];
    logic [1:0] m_stop   [2];
    int         m_cnt    [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_blk[k] = 0; m_pls[k] = 0;
            m_info[k] = 2'b00; m_stop[k] = 2'b00; m_cnt[k] = 0;
        end
    endtask

    task automatic model_edge(input logic en, input logic clr, input logic [1:0] ax,
                              input logic [1:0] id, input logic [1:0] cb);
        bit cond;
        cond = (ax != 2'b00) && ((ax | id | cb) == 2'b11);
        for (int k = 0; k < 2; k++) begin
            m_stop[k] = ax | id | cb;
            m_pls[k]  = 0;
            if (clr) begin
                m_blk[k] = 0; m_info[k] = 2'b00; m_run[k] = 0;
            end else if (m_blk[k]) begin
                if (!p_sticky[k]) begin
                    if (cond) m_info[k] = ax;
                    else begin m_blk[k] = 0; m_info[k] = 2'b00; m_run[k] = 0; end
                end
            end else begin
                m_run[k] = (en && cond) ? m_run[k] + 1 : 0;
                if (m_run[k] == p_stable[k]) begin
                    m_blk[k] = 1; m_pls[k] = 1; m_info[k] = ax;
                    if (m_cnt[k] < p_max[k]) m_cnt[k]++;
                end
            end
        end
    endtask

    task automatic model_check();
        chk("a.block", 32'(blk_a), 32'(m_blk[0]));
        chk("a.pulse", 32'(pls_a), 32'(m_pls[0]));
        chk("a.info",  32'(info_a), 32'(m_info[0]));
        chk("a.stop",  32'(stop_a), 32'(m_stop[0]));
        chk("a.count", 32'(cnt_a), 32'(m_cnt[0]));
        chk("b.block", 32'(blk_b), 32'(m_blk[1]));
        chk("b.pulse", 32'(pls_b), 32'(m_pls[1]));
        chk("b.info",  32'(info_b), 32'(m_info[1]));
        chk("b.stop",  32'(stop_b), 32'(m_stop[1]));
        chk("b.count", 32'(cnt_b), 32'(m_cnt[1]));
    endtask

    task automatic zero_check(input string tag);
        chk({tag, ".a.block"}, 32'(blk_a), 0);
        chk({tag, ".a.pulse"}, 32'(pls_a), 0);
        chk({tag, ".a.info"},  32'(info_a), 0);
        chk({tag, ".a.stop"},  32'(stop_a), 0);
        chk({tag, ".a.count"}, 32'(cnt_a), 0);
        chk({tag, ".b.block"}, 32'(blk_b), 0);
        chk({tag, ".b.pulse"}, 32'(pls_b), 0);
        chk({tag, ".b.info"},  32'(info_b), 0);
        chk({tag, ".b.stop"},  32'(stop_b), 0);
        chk({tag, ".b.count"}, 32'(cnt_b), 0);
    endtask

    // Inputs change 1 time unit after an edge; outputs are checked 1 unit after the next edge.
    task automatic step(input logic en, input logic clr, input logic [1:0] ax,
                        input logic [1:0] id, input logic [1:0] cb);
        enable = en; clear = clr;
        axis_block_sigs = ax; inst_idle_sigs = id; inst_block_sigs = cb;
        @(posedge clock);
        model_edge(en, clr, ax, id, cb);
        #1;
        model_check();
    endtask

    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        #1 zero_check(tag);
        model_reset();
        #2 reset_n = 1'b1;
    endtask

    typedef struct {
        logic       en, clr;
        logic [1:0] ax, id, cb;
        logic       eb, ep;
        logic [1:0] ei, es;
        logic [7:0] ec;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic en, input logic clr, input logic [1:0] ax, input logic [1:0] id,
                       input logic [1:0] cb, input logic eb, input logic ep, input logic [1:0] ei,
                       input logic [1:0] es, input logic [7:0] ec);
        vec_t v;
        v.en = en; v.clr = clr; v.ax = ax; v.id = id; v.cb = cb;
        v.eb = eb; v.ep = ep; v.ei = ei; v.es = es; v.ec = ec;
        tbl.push_back(v);
    endtask

    initial begin
        logic       en_r, clr_r;
        logic [1:0] ax_r, id_r, cb_r;

        // Expected outputs of instance a (STABLE_CYCLES=4, sticky) after each edge.
        for (int i = 0; i < 3; i++) add(1, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 2'b11, 0);
        add(1, 0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 2'b01, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 2'b11, 0);
        add(1, 0, 2'b01, 2'b10, 2'b00, 1, 1, 2'b01, 2'b11, 1);
        for (int i = 0; i < 5; i++) add(0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 2'b01, 2'b00, 1);
        add(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 1);
        add(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 1);
        for (int i = 0; i < 3; i++) add(1, 0, 2'b10, 2'b00, 2'b01, 0, 0, 2'b00, 2'b11, 1);
        add(1, 0, 2'b10, 2'b00, 2'b01, 1, 1, 2'b10, 2'b11, 2);
        add(1, 1, 2'b10, 2'b00, 2'b01, 0, 0, 2'b00, 2'b11, 2);
        for (int i = 0; i < 3; i++) add(1, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 2'b11, 2);
        add(1, 1, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 2'b11, 2);
        add(1, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 2'b11, 2);
        add(0, 0, 2'b01, 2'b10, 2'b00, 0, 0, 2'b00, 2'b11, 2);

        reset_n = 1'b0; enable = 1'b0; clear = 1'b0;
        axis_block_sigs = 2'b00; inst_idle_sigs = 2'b00; inst_block_sigs = 2'b00;
        model_reset();
        #22;
        zero_check("reset");
        reset_n = 1'b1;

        // Transient instance b: one-cycle latency, clears on drop, count saturates at 3.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 2'b01, 2'b10, 2'b00);
            chk("b.det.block", 32'(blk_b), 1);
            chk("b.det.pulse", 32'(pls_b), 1);
            chk("b.det.count", 32'(cnt_b), (i < 3) ? 32'(i + 1) : 32'd3);
            step(1, 0, 2'b00, 2'b00, 2'b00);
            chk("b.drop.block", 32'(blk_b), 0);
            chk("b.drop.info", 32'(info_b), 0);
            chk("a.short_run.block", 32'(blk_a), 0);
        end

        for (int r = 0; r < tbl.size(); r++) begin
            step(tbl[r].en, tbl[r].clr, tbl[r].ax, tbl[r].id, tbl[r].cb);
            chk($sformatf("tbl%0d.block", r), 32'(blk_a), 32'(tbl[r].eb));
            chk($sformatf("tbl%0d.pulse", r), 32'(pls_a), 32'(tbl[r].ep));
            chk($sformatf("tbl%0d.info", r), 32'(info_a), 32'(tbl[r].ei));
            chk($sformatf("tbl%0d.stop", r), 32'(stop_a), 32'(tbl[r].es));
            chk($sformatf("tbl%0d.count", r), 32'(cnt_a), 32'(tbl[r].ec));
        end

        for (int i = 0; i < 10; i++) begin
            step(1, 0, 2'b00, 2'b11, 2'b00);
            chk("allidle.a.block", 32'(blk_a), 0);
            chk("allidle.b.block", 32'(blk_b), 0);
            chk("allidle.a.stop", 32'(stop_a), 32'd3);
        end

        for (int i = 0; i < 2; i++) step(1, 0, 2'b01, 2'b10, 2'b00);
        async_reset("rst_arming");
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 2'b01, 2'b10, 2'b00);
            chk("rearm.a.block", 32'(blk_a), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("rearm.a.count", 32'(cnt_a), 1);
        async_reset("rst_blocked");
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 2'b01, 2'b10, 2'b00);
            chk("rearm2.a.block", 32'(blk_a), (i == 4) ? 32'd1 : 32'd0);
        end

        en_r = 1'b1; clr_r = 1'b0; ax_r = 2'b01; id_r = 2'b10; cb_r = 2'b00;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) begin
                ax_r = 2'($urandom);
                id_r = 2'($urandom) | 2'($urandom);
                cb_r = 2'($urandom);
                en_r = ($urandom_range(7) != 0);
            end
            clr_r = ($urandom_range(40) == 0);
            step(en_r, clr_r, ax_r, id_r, cb_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/deadlock_axis_monitor_param.md
Name: deadlock_axis_monitor_param

Overview:
- Parametrised dataflow deadlock monitor for a region containing NUM_PROC processes, each with one AXI-stream port.
- Flags a deadlock when at least one process is blocked on AXI-stream and every process is stopped (idle, channel-blocked or axis-blocked).
- Adds three capabilities: a persistence filter, sticky or transient reporting, and a detection event counter.
- Instantiated by the simulation wrapper around each dataflow instance; its outputs feed the deadlock reporter.

Parameters:
- NUM_PROC, 2: number of monitored processes and AXI-stream block inputs (>=1).
- STABLE_CYCLES, 4: consecutive cycles the deadlock condition must hold before block asserts (>=1).
- STICKY, 1: 1 = block/info held until clear; 0 = they follow the condition.
- CNT_W, 8: width of the detection event counter.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  arms detection; 0 suppresses new detections.
- clear  in  1  synchronous clear of block/info/arming state.
- axis_block_sigs  in  NUM_PROC  bit i = process i stalled on its AXI-stream port.
- inst_idle_sigs  in  NUM_PROC  bit i = process i idle.
- inst_block_sigs  in  NUM_PROC  bit i = process i blocked on an internal channel.
- block  out  1  deadlock detected.
- block_pulse  out  1  one-cycle strobe on each detection.
- axis_block_info  out  NUM_PROC  axis-blocked process vector at detection; 0 when block=0.
- stop_vec  out  NUM_PROC  registered per-process stop status.
- block_count  out  CNT_W  saturating count of detections.

Behaviour:
- Combinational terms:
  - stop[i] = idle[i] | chan_block[i] | axis_block[i].
  - has_axis = |axis_block_sigs.
  - cond = has_axis & (&stop).
- reset_n low (asynchronous, any state): state=IDLE, run_cnt=0; block, block_pulse, axis_block_info, stop_vec, block_count all 0.
- stop_vec <= stop every cycle. Unaffected by enable and clear.
- run_cnt width = clog2(STABLE_CYCLES+1).
- Condition-holding counts and latency:
  - cond sampled true at N consecutive edges: block=1 after the edge where N reaches STABLE_CYCLES.
  - STABLE_CYCLES=1 gives one-cycle registered latency.
- FSM states IDLE, ARMING, BLOCKED; clear has highest priority after reset.
- IDLE:
  - enable & cond: run_cnt<=1; go to BLOCKED if STABLE_CYCLES==1, else ARMING.
  - otherwise stay, run_cnt<=0.
- ARMING:
  - !enable or !cond: go to IDLE, run_cnt<=0.
  - cond and run_cnt+1==STABLE_CYCLES: go to BLOCKED.
  - otherwise run_cnt<=run_cnt+1.
- Entry to BLOCKED (same edge), all together:
  - block<=1 and block_pulse<=1 for exactly one cycle.
  - axis_block_info<=axis_block_sigs.
  - block_count<=block_count+1, saturating at all-ones.
- BLOCKED, STICKY=1:
  - Stay regardless of inputs and enable; info frozen.
  - Leave only on clear or reset.
- BLOCKED, STICKY=0:
  - cond: stay, axis_block_info<=axis_block_sigs each cycle.
  - !cond: go to IDLE; block<=0, info<=0, run_cnt<=0.
  - enable is ignored while BLOCKED.
- clear=1 (any state):
  - Next state IDLE; block<=0, info<=0, run_cnt<=0, block_pulse<=0.
  - block_count and stop_vec are not cleared.
  - clear has priority over a simultaneous detection, so no pulse and no count increment.
- Re-detection requires a full new STABLE_CYCLES run from IDLE.
- All-idle with no axis block is never a deadlock (has_axis=0).

Test Plan:
- NUM_PROC=2, STABLE_CYCLES=4, STICKY=1:
  - Stimulus: axis_block_sigs=2'b01, inst_idle_sigs=2'b10 held.
  - Required: block=1 after 4th edge; block_pulse high 1 cycle; axis_block_info=2'b01; block_count=1.
- Same condition held 3 edges, then inst_idle_sigs=2'b00 -> block never asserts; block_count=0; FSM back in IDLE.
- axis_block_sigs=0, inst_idle_sigs=2'b11 held 10 cycles -> block=0 throughout; stop_vec=2'b11.
- STICKY=1 after detection:
  - Drop all inputs for 5 cycles: block=1, info=2'b01 held.
  - Pulse clear: block=0, info=0 next edge; block_count stays 1.
  - Assert clear on the detection edge: no pulse, count unchanged.
- STICKY=0 with CNT_W=2:
  - After detection, drop cond: block=0 next edge.
  - Repeat detection 4 times: block_count=1,2,3,3 (saturates).
- Assert reset_n low mid-ARMING and mid-BLOCKED, between clock edges -> all outputs 0 immediately; a fresh 4-cycle run is needed after release.
